// File: rtl/littlecpu_dmem.sv
// littlecpu_dmem: single-outstanding data-memory responder for the core's load/store port.
// It holds a word-organised SRAM with byte-strobe writes and answers each request after
// WAIT_CYCLES wait states with a one-cycle mem_valid pulse. Misaligned and out-of-range
// requests get a fault response and never touch the SRAM.
//
// Ports:
//   clk        - clock, all state on the rising edge
//   reset      - asynchronous active-low reset
//   mem_ready  - request strobe, held by the core until it sees mem_valid
//   mem_addr   - byte address of the request
//   mem_wdata  - write data, byte lanes selected by mem_wstrb
//   mem_wstrb  - byte write enables, 4'b0000 means read
//   mem_valid  - one-cycle response pulse
//   mem_rdata  - read data (old word contents on writes), 0 outside the response cycle
//   mem_fault  - qualifies mem_valid for misaligned/out-of-range requests
//
// Optional build macro LITTLECPU_DMEM_STATS_EN adds saturating counters stat_reads,
// stat_writes and stat_faults, cleared by reset.
module littlecpu_dmem #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_valid,
  output logic [31:0] mem_rdata,
`ifdef LITTLECPU_DMEM_STATS_EN
  output logic [31:0] stat_reads,
  output logic [31:0] stat_writes,
  output logic [31:0] stat_faults,
`endif
  output logic        mem_fault
);

  localparam int unsigned AddrW     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SpanBytes = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WaitLoad  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        valid_q, fault_q;
  logic [31:0] rdata_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0]      req_addr, req_wdata;
  logic [3:0]       req_wstrb;
  logic [32:0]      req_off;
  logic             req_fault;
  logic [AddrW-1:0] req_idx;
  logic [31:0]      old_word, new_word;
  logic             enter_resp, do_write;

  // In IDLE the live inputs are the request (needed when WAIT_CYCLES is 0 and the response
  // is produced on the accepting edge); afterwards the captured copy is used.
  always_comb begin
    req_addr  = (state_q == StIdle) ? mem_addr  : addr_q;
    req_wdata = (state_q == StIdle) ? mem_wdata : wdata_q;
    req_wstrb = (state_q == StIdle) ? mem_wstrb : wstrb_q;
    // 33-bit offset: an address below BASE_ADDR wraps to a huge value and fails the range test.
    req_off   = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    req_fault = (req_addr[1:0] != 2'b00) || (req_off >= SpanBytes);
    req_idx   = req_off[AddrW+1:2];
    old_word  = mem_q[req_idx];
    for (int i = 0; i < 4; i++) begin
      new_word[8*i +: 8] = req_wstrb[i] ? req_wdata[8*i +: 8] : old_word[8*i +: 8];
    end
    enter_resp = ((state_q == StIdle) && mem_ready && (WAIT_CYCLES == 0)) ||
                 ((state_q == StWait) && (cnt_q == 4'd0));
    // Gate with reset so a request presented while reset is held never commits.
    do_write   = enter_resp && reset && !req_fault && (req_wstrb != 4'b0000);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      valid_q <= 1'b0;
      rdata_q <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      rdata_q <= 32'd0;
      fault_q <= 1'b0;
      if (enter_resp) begin
        valid_q <= 1'b1;
        rdata_q <= req_fault ? 32'd0 : old_word;
        fault_q <= req_fault;
      end
      case (state_q)
        StIdle: begin
          if (mem_ready) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
            if (WAIT_CYCLES == 0) begin
              state_q <= StResp;
            end else begin
              state_q <= StWait;
              cnt_q   <= WaitLoad;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) state_q <= StResp;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // SRAM: no reset, read-before-write on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (do_write) mem_q[req_idx] <= new_word;
  end

  assign mem_valid = valid_q;
  assign mem_rdata = rdata_q;
  assign mem_fault = fault_q;

`ifdef LITTLECPU_DMEM_STATS_EN
  logic [31:0] reads_q, writes_q, faults_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reads_q  <= 32'd0;
      writes_q <= 32'd0;
      faults_q <= 32'd0;
    end else if (enter_resp) begin
      if (req_fault) begin
        if (faults_q != 32'hFFFF_FFFF) faults_q <= faults_q + 32'd1;
      end else if (req_wstrb != 4'b0000) begin
        if (writes_q != 32'hFFFF_FFFF) writes_q <= writes_q + 32'd1;
      end else begin
        if (reads_q != 32'hFFFF_FFFF) reads_q <= reads_q + 32'd1;
      end
    end
  end

  assign stat_reads  = reads_q;
  assign stat_writes = writes_q;
  assign stat_faults = faults_q;
`endif

endmodule

// File: tb/tb_littlecpu_dmem.sv
// Scoreboard bench for littlecpu_dmem: three instances with WAIT_CYCLES 0, 1 and 3.
// Stimulus pushes the expected response (cycle, rdata, fault) into a queue; the monitor
// pops and compares on every mem_valid, and flags responses that are late or missing.
module tb_littlecpu_dmem;

  typedef struct {
    int          dut;
    int          cyc;
    logic [31:0] rdata;
    logic        fault;
    logic        dc;  // old contents unknown, skip rdata compare
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ready [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  wstrb [3];
  logic        valid [3];
  logic [31:0] rdata [3];
  logic        fault [3];
`ifdef LITTLECPU_DMEM_STATS_EN
  logic [31:0] st_r [3];
  logic [31:0] st_w [3];
  logic [31:0] st_f [3];
`endif

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_rd [3];
  int   n_wr [3];
  int   n_ft [3];
  logic stat_chk = 1'b0;
  exp_t exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 0 : (g == 1) ? 1 : 3;
    littlecpu_dmem #(
      .DEPTH_WORDS(1024),
      .BASE_ADDR  (32'h0000_0000),
      .WAIT_CYCLES(W)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .mem_ready  (ready[g]),
      .mem_addr   (addr[g]),
      .mem_wdata  (wdata[g]),
      .mem_wstrb  (wstrb[g]),
      .mem_valid  (valid[g]),
      .mem_rdata  (rdata[g]),
`ifdef LITTLECPU_DMEM_STATS_EN
      .stat_reads (st_r[g]),
      .stat_writes(st_w[g]),
      .stat_faults(st_f[g]),
`endif
      .mem_fault  (fault[g])
    );
  end

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 1 : 3;
  endfunction

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (valid[g] || rdata[g] != 32'd0 || fault[g]) begin
          errors++;
          $display("FAIL reset_state dut%0d got valid=%b rdata=%h fault=%b want 0/0/0",
                   g, valid[g], rdata[g], fault[g]);
        end
`ifdef LITTLECPU_DMEM_STATS_EN
        checks++;
        if (st_r[g] != 0 || st_w[g] != 0 || st_f[g] != 0) begin
          errors++;
          $display("FAIL reset_stats dut%0d got r=%0d w=%0d f=%0d want 0/0/0",
                   g, st_r[g], st_w[g], st_f[g]);
        end
`endif
      end
    end else begin
      for (int g = 0; g < 3; g++) begin
        if (valid[g]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp dut%0d cyc%0d rdata=%h fault=%b want none",
                     g, cyc, rdata[g], fault[g]);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.dut != g || e.cyc != cyc || (!e.dc && rdata[g] != e.rdata) ||
                fault[g] != e.fault) begin
              errors++;
              $display("FAIL resp dut%0d cyc%0d rdata=%h fault=%b want dut%0d cyc%0d rdata=%h%s fault=%b",
                       g, cyc, rdata[g], fault[g], e.dut, e.cyc, e.rdata,
                       e.dc ? "(any)" : "", e.fault);
            end
          end
        end else if (rdata[g] != 32'd0 || fault[g]) begin
          checks++;
          errors++;
          $display("FAIL idle_outputs dut%0d cyc%0d rdata=%h fault=%b want 0/0",
                   g, cyc, rdata[g], fault[g]);
        end
      end
      if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_resp dut%0d now cyc%0d want valid at cyc%0d", e.dut, cyc, e.cyc);
      end
`ifdef LITTLECPU_DMEM_STATS_EN
      if (stat_chk) begin
        for (int g = 0; g < 3; g++) begin
          checks++;
          if (st_r[g] != 32'(n_rd[g]) || st_w[g] != 32'(n_wr[g]) || st_f[g] != 32'(n_ft[g])) begin
            errors++;
            $display("FAIL stats dut%0d got r=%0d w=%0d f=%0d want r=%0d w=%0d f=%0d",
                     g, st_r[g], st_w[g], st_f[g], n_rd[g], n_wr[g], n_ft[g]);
          end
        end
      end
`endif
    end
  end

  function automatic void tally(input int d, input logic [3:0] ws, input logic ef);
    if (ef)              n_ft[d]++;
    else if (ws != 4'h0) n_wr[d]++;
    else                 n_rd[d]++;
  endfunction

  // Called at a falling edge with the DUT idle: one request held until mem_valid.
  task automatic req(input int d, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] ws, input logic [31:0] er, input logic ef,
                     input logic dc);
    exp_t e;
    logic seen;
    e.dut = d; e.cyc = cyc + 1 + wait_of(d); e.rdata = er; e.fault = ef; e.dc = dc;
    exp_q.push_back(e);
    tally(d, ws, ef);
    ready[d] = 1'b1; addr[d] = a; wdata[d] = wd; wstrb[d] = ws;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = valid[d];
    end
    ready[d] = 1'b0;
    @(negedge clk);
  endtask

  // WAIT_CYCLES=0 instance with mem_ready left high: a new vector every two cycles.
  task automatic stream_step(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                             input logic [31:0] er, input logic ef, input logic dc);
    exp_t e;
    e.dut = 0; e.cyc = cyc + 1; e.rdata = er; e.fault = ef; e.dc = dc;
    exp_q.push_back(e);
    tally(0, ws, ef);
    ready[0] = 1'b1; addr[0] = a; wdata[0] = wd; wstrb[0] = ws;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      ready[g] = 1'b0; addr[g] = '0; wdata[g] = '0; wstrb[g] = '0;
      n_rd[g] = 0; n_wr[g] = 0; n_ft[g] = 0;
    end
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);

    // WAIT_CYCLES=1: full-word, byte-strobe, fault and boundary accesses.
    req(1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 1'b1);
    req(1, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    req(1, 32'h20,  32'h11223344, 4'hF, 32'h0,        1'b0, 1'b1);
    req(1, 32'h20,  32'hAABBCCDD, 4'h5, 32'h11223344, 1'b0, 1'b0);
    req(1, 32'h20,  32'h0,        4'h0, 32'h11BB33DD, 1'b0, 1'b0);
    req(1, 32'h0,   32'h01020304, 4'hF, 32'h0,        1'b0, 1'b1);
    req(1, 32'h22,  32'h0,        4'h0, 32'h0,        1'b1, 1'b0);
    req(1, 32'h1000, 32'h0,       4'h0, 32'h0,        1'b1, 1'b0);
    req(1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0,       1'b1, 1'b0);
    req(1, 32'h21,  32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 1'b0);
    req(1, 32'h20,  32'h0,        4'h0, 32'h11BB33DD, 1'b0, 1'b0);
    req(1, 32'h0,   32'h0,        4'h0, 32'h01020304, 1'b0, 1'b0);
    req(1, 32'hFFC, 32'hA5A5A5A5, 4'hF, 32'h0,        1'b0, 1'b1);
    req(1, 32'hFFC, 32'h0,        4'h0, 32'hA5A5A5A5, 1'b0, 1'b0);

    // WAIT_CYCLES=0, continuous mem_ready.
    stream_step(32'h50, 32'h55AA0011, 4'hF, 32'h0,        1'b0, 1'b1);
    stream_step(32'h50, 32'h66778899, 4'hF, 32'h55AA0011, 1'b0, 1'b0);
    stream_step(32'h50, 32'h000000EE, 4'h1, 32'h66778899, 1'b0, 1'b0);
    stream_step(32'h50, 32'h0,        4'h0, 32'h667788EE, 1'b0, 1'b0);
    stream_step(32'h52, 32'h0,        4'h0, 32'h0,        1'b1, 1'b0);
    stream_step(32'h50, 32'h0,        4'h0, 32'h667788EE, 1'b0, 1'b0);
    ready[0] = 1'b0;
    @(negedge clk);

    // Counter snapshot before any mid-test reset clears them.
    #2 stat_chk = 1'b1;
    @(negedge clk);
    #2 stat_chk = 1'b0;
    @(negedge clk);

    // WAIT_CYCLES=3: reset during WAIT discards the write.
    req(2, 32'h40, 32'h12345678, 4'hF, 32'h0,        1'b0, 1'b1);
    req(2, 32'h40, 32'h0,        4'h0, 32'h12345678, 1'b0, 1'b0);
    ready[2] = 1'b1; addr[2] = 32'h40; wdata[2] = 32'hCAFEF00D; wstrb[2] = 4'hF;
    @(negedge clk);
    ready[2] = 1'b0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    req(2, 32'h40, 32'h0, 4'h0, 32'h12345678, 1'b0, 1'b0);

    // Reset just after the RESP-entry edge: pulse cut short, write already committed.
    ready[2] = 1'b1; addr[2] = 32'h44; wdata[2] = 32'h0BADCAFE; wstrb[2] = 4'hF;
    repeat (4) @(posedge clk);
    ready[2] = 1'b0;
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    req(2, 32'h44, 32'h0, 4'h0, 32'h0BADCAFE, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
